// File: rtl/param_alu_mem_engine.sv
// Parametrised memory/register micro-ALU engine.
// Accepts one instruction per four clocks over a valid/ready handshake.
// Each instruction reads two operands from an internal register memory into r1/r2,
// computes r3 and its flags, and writes r3 back to memory.
module param_alu_mem_engine #(
  parameter  int DW = 8,
  parameter  int AW = 4,
  localparam int IW = 4 + 3 * AW + DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] instr,
  input  logic          instr_valid,
  output logic          instr_ready,
  output logic          done,
  output logic [DW-1:0] r1,
  output logic [DW-1:0] r2,
  output logic [DW-1:0] r3,
  output logic          carry,
  output logic          zero,
  output logic          div0,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  localparam int DEPTH = 2 ** AW;
  localparam int SW    = $clog2(DW);

  localparam logic [3:0] OP_LOADI = 4'd0,  OP_EQ   = 4'd1,  OP_LT  = 4'd2,  OP_LE   = 4'd3;
  localparam logic [3:0] OP_OR    = 4'd4,  OP_AND  = 4'd5,  OP_XOR = 4'd6,  OP_NOT  = 4'd7;
  localparam logic [3:0] OP_ADD   = 4'd8,  OP_SUB  = 4'd9,  OP_MUL = 4'd10, OP_MULH = 4'd11;
  localparam logic [3:0] OP_DIV   = 4'd12, OP_MOD  = 4'd13, OP_SHL = 4'd14, OP_NOP  = 4'd15;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

  state_t        state, state_next;
  logic [IW-1:0] ir;
  logic [DW-1:0] mem [DEPTH];

  // Fields of the latched instruction; the live instr input is ignored once accepted.
  logic [3:0]    op;
  logic [AW-1:0] a, b, d;
  logic [DW-1:0] imm;
  assign op  = ir[IW-1 -: 4];
  assign a   = ir[3*AW+DW-1 -: AW];
  assign b   = ir[2*AW+DW-1 -: AW];
  assign d   = ir[AW+DW-1 -: AW];
  assign imm = ir[DW-1:0];

  assign rd_data = mem[rd_addr];

  // ALU intermediate values
  logic [DW:0]     sum;
  logic [2*DW-1:0] prod;
  logic [DW-1:0]   alu_res;
  logic            alu_carry;
  logic            alu_div0;
  logic            r2_zero;

  assign sum     = {1'b0, r1} + {1'b0, r2};
  assign prod    = {{DW{1'b0}}, r1} * {{DW{1'b0}}, r2};
  assign r2_zero = (r2 == '0);

  // State register: reset aborts any instruction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state: one state per clock, leave IDLE only on a handshake.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (instr_valid) state_next = READ;
      READ:    state_next = EXEC;
      EXEC:    state_next = WRITE;
      WRITE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    instr_ready = (state == IDLE);
  end

  // ALU: result, carry/borrow and divide-by-zero detection for the latched opcode.
  always_comb begin
    alu_res   = r3;
    alu_carry = carry;
    alu_div0  = 1'b0;
    case (op)
      OP_LOADI: alu_res = imm;
      OP_EQ:    alu_res = {{(DW-1){1'b0}}, (r1 == r2)};
      OP_LT:    alu_res = {{(DW-1){1'b0}}, (r1 <  r2)};
      OP_LE:    alu_res = {{(DW-1){1'b0}}, (r1 <= r2)};
      OP_OR:    alu_res = r1 | r2;
      OP_AND:   alu_res = r1 & r2;
      OP_XOR:   alu_res = r1 ^ r2;
      OP_NOT:   alu_res = ~r1;
      OP_ADD:   begin alu_res = sum[DW-1:0]; alu_carry = sum[DW]; end
      OP_SUB:   begin alu_res = r1 - r2;     alu_carry = (r1 < r2); end
      OP_MUL:   alu_res = prod[DW-1:0];
      OP_MULH:  alu_res = prod[2*DW-1:DW];
      OP_DIV:   begin
                  alu_res  = r2_zero ? {DW{1'b1}} : (r1 / r2);
                  alu_div0 = r2_zero;
                end
      OP_MOD:   begin
                  alu_res  = r2_zero ? r1 : (r1 % r2);
                  alu_div0 = r2_zero;
                end
      OP_SHL:   alu_res = r1 << r2[SW-1:0];
      default:  alu_res = r3;  // NOP keeps r3
    endcase
  end

  // Datapath: instruction latch, operand fetch, result/flags, write-back and done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir    <= '0;
      r1    <= '0;
      r2    <= '0;
      r3    <= '0;
      carry <= 1'b0;
      zero  <= 1'b0;
      div0  <= 1'b0;
      done  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (instr_valid) ir <= instr;
        READ: begin
          r1 <= mem[a];
          r2 <= mem[b];
        end
        EXEC: if (op != OP_NOP) begin
          r3    <= alu_res;
          carry <= alu_carry;
          zero  <= (alu_res == '0);
          if (alu_div0) div0 <= 1'b1;
        end
        WRITE: begin
          if (op != OP_NOP) mem[d] <= r3;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_param_alu_mem_engine.sv
// Directed testbench for param_alu_mem_engine (DW=8, AW=4).
module tb_param_alu_mem_engine;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int IW = 4 + 3 * AW + DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [IW-1:0] instr = '0;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic          done;
  logic [DW-1:0] r1, r2, r3;
  logic          carry, zero, div0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;

  int vectors = 0;
  int errs    = 0;

  param_alu_mem_engine #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .done(done), .r1(r1), .r2(r2), .r3(r3),
    .carry(carry), .zero(zero), .div0(div0), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Read memory word through the debug port.
  task automatic peek(input logic [AW-1:0] addr, output logic [DW-1:0] val);
    rd_addr = addr;
    #1;
    val = rd_data;
  endtask

  // Issue one instruction and return the number of clocks from accept to done.
  task automatic send(input logic [3:0] op, input logic [AW-1:0] a, input logic [AW-1:0] b,
                      input logic [AW-1:0] d, input logic [DW-1:0] imm, output int lat);
    lat = 0;
    @(negedge clk);
    for (int k = 0; k < 8 && !instr_ready; k++) @(negedge clk);
    instr = {op, a, b, d, imm};
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    instr = '1;  // must be ignored after accept
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) @(negedge clk);
      if (done) begin lat = k; break; end
    end
    $display("instr op=%0d a=%0d b=%0d d=%0d imm=%0d -> r3=%0h carry=%0b zero=%0b div0=%0b lat=%0d",
             op, a, b, d, imm, r3, carry, zero, div0, lat);
  endtask

  initial begin
    int lat;
    int accepts, dones;
    logic [DW-1:0] v;

    // Reset state
    #12;
    chk("rst_ready", instr_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_r3", r3, 0);
    chk("rst_flags", {carry, zero, div0}, 0);
    @(negedge clk); rst = 1'b0;

    // LOADI 5->m1, 7->m2, ADD -> m3=12
    send(4'd0, 0, 0, 1, 8'd5, lat);
    chk("loadi_lat", lat, 4);
    send(4'd0, 0, 0, 2, 8'd7, lat);
    send(4'd8, 1, 2, 3, 8'd0, lat);
    chk("add_lat", lat, 4);
    chk("add_r3", r3, 12);
    chk("add_flags", {carry, zero}, 2'b00);
    peek(3, v); chk("add_m3", v, 12);
    @(negedge clk);
    chk("done_pulse_len", done, 0);
    // SUB equal operands -> zero flag
    send(4'd9, 1, 1, 5, 8'd0, lat);
    chk("sub0_r3", r3, 0);
    chk("sub0_flags", {carry, zero}, 2'b01);

    // ADD overflow / SUB borrow
    send(4'd0, 0, 0, 1, 8'd200, lat);
    send(4'd0, 0, 0, 2, 8'd100, lat);
    send(4'd8, 1, 2, 3, 8'd0, lat);
    chk("addc_r3", r3, 44);
    chk("addc_carry", carry, 1);
    send(4'd9, 2, 1, 4, 8'd0, lat);
    chk("subb_r3", r3, 156);
    chk("subb_carry", carry, 1);
    // NOP: operands loaded, r3 and memory untouched, done still pulses
    send(4'd15, 1, 2, 3, 8'd0, lat);
    chk("nop_lat", lat, 4);
    chk("nop_r1r2", {r1, r2}, {8'd200, 8'd100});
    chk("nop_r3", r3, 156);
    peek(3, v); chk("nop_m3", v, 44);

    // MUL / MULH / compares
    send(4'd0, 0, 0, 2, 8'd200, lat);
    send(4'd10, 1, 2, 5, 8'd0, lat);
    chk("mul_r3", r3, 8'h40);
    chk("mul_carry_held", carry, 1);
    send(4'd11, 1, 2, 5, 8'd0, lat);
    chk("mulh_r3", r3, 8'h9C);
    send(4'd1, 1, 2, 6, 8'd0, lat);
    chk("eq_r3", r3, 1);
    send(4'd2, 1, 2, 6, 8'd0, lat);
    chk("lt_r3", r3, 0);
    chk("lt_zero", zero, 1);
    send(4'd3, 1, 2, 6, 8'd0, lat);
    chk("le_r3", r3, 1);

    // Divide by zero, sticky div0, then valid DIV/MOD
    send(4'd12, 1, 0, 6, 8'd0, lat);
    chk("div0_r3", r3, 8'hFF);
    chk("div0_flag", div0, 1);
    send(4'd13, 1, 0, 6, 8'd0, lat);
    chk("mod0_r3", r3, 200);
    send(4'd0, 0, 0, 7, 8'd7, lat);
    send(4'd12, 1, 7, 6, 8'd0, lat);
    chk("div_r3", r3, 28);
    chk("div0_sticky", div0, 1);
    send(4'd13, 1, 7, 6, 8'd0, lat);
    chk("mod_r3", r3, 4);
    send(4'd6, 1, 7, 8, 8'd0, lat);
    chk("xor_r3", r3, 8'hCF);
    send(4'd7, 7, 1, 8, 8'd0, lat);
    chk("not_r3", r3, 8'hF8);
    send(4'd0, 0, 0, 9, 8'd3, lat);
    send(4'd14, 7, 9, 10, 8'd0, lat);
    chk("shl_r3", r3, 8'h38);
    // d == a: operands already captured
    send(4'd8, 7, 7, 7, 8'd0, lat);
    peek(7, v); chk("d_eq_a_m7", v, 14);

    // Reset during EXEC of LOADI 9->m4
    @(negedge clk);
    instr = {4'd0, 4'd0, 4'd0, 4'd4, 8'd9};
    instr_valid = 1'b1;
    @(posedge clk);            // accept
    @(negedge clk); instr_valid = 1'b0;
    @(negedge clk);            // now in EXEC
    rst = 1'b1;
    #1;
    chk("abort_ready", instr_ready, 1);
    @(negedge clk); rst = 1'b0;
    dones = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("abort_no_done", dones, 0);
    chk("abort_ready_after", instr_ready, 1);
    peek(4, v); chk("abort_m4", v, 0);
    chk("abort_div0", div0, 0);

    // valid held high 12 clocks with ADD m3 = m3 + m1
    send(4'd0, 0, 0, 1, 8'd5, lat);
    rd_addr = 3;
    @(negedge clk);
    instr = {4'd8, 4'd3, 4'd1, 4'd3, 8'd0};
    instr_valid = 1'b1;
    accepts = 0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (instr_ready) accepts++;
      @(negedge clk);
      if (done) begin
        dones++;
        chk("stream_rd_data", rd_data, 5 * dones);
      end
    end
    instr_valid = 1'b0;
    chk("stream_accepts", accepts, 3);
    chk("stream_dones", dones, 3);
    @(negedge clk);
    chk("stream_idle", {instr_ready, done}, 2'b10);
    chk("stream_m3_final", rd_data, 15);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
